// File: rtl/reset_sequencer.sv
// Staggered per-stage reset release after the synchronized system reset deasserts, with a
// synchronous soft-reset request that re-runs the whole sequence from RUN.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 5,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STAGGER     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  ready
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_STAGES + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(STAGGER - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    case (state_q)
      StHold: begin
        if (cnt_q == HoldLast) begin
          stage_d = NUM_STAGES'(1);
          cnt_d   = '0;
          if (NUM_STAGES == 1) begin
            ready_d = 1'b1;
            state_d = StRun;
          end else begin
            idx_d   = IdxW'(1);
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (cnt_q == StagLast) begin
          // Shifting a one in keeps the output a thermometer code: bits 0..idx set.
          stage_d = (stage_q << 1) | NUM_STAGES'(1);
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            ready_d = 1'b1;
            state_d = StRun;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (soft_rst_req) begin
          stage_d = '0;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StHold;
        end
      end
      default: begin
        stage_d = '0;
        ready_d = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = StHold;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
    end
  end

  assign stage_reset_n = stage_q;
  assign ready         = ready_q;

endmodule
